// File: rtl/button_event_arbiter_if.sv
// -----------------------------------------------------------------------------
// button_event_arbiter_if
// Event handshake between the button arbiter and its single consumer.
//   evt_valid : arbiter -> consumer, an event is offered on evt_id
//   evt_id    : arbiter -> consumer, channel index of the offered event
//   evt_ready : consumer -> arbiter, offered event is taken on this edge
// master modport is used by the arbiter, slave modport by the consumer.
// -----------------------------------------------------------------------------
interface button_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_ready;

    modport master (
        output evt_valid,
        output evt_id,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        output evt_ready
    );
endinterface

// File: rtl/button_event_arbiter.sv
// -----------------------------------------------------------------------------
// button_event_arbiter
// Synchronizes and debounces NUM_BTN raw push buttons, turns every debounced
// rising edge into a pending event and hands pending events one at a time to a
// single consumer in round-robin order over a valid/ready handshake.
//
// Ports:
//   MHz10       : system clock, everything on its rising edge
//   nrst        : synchronous active-low reset
//   en          : sampling enable; low freezes debounce state (sync always runs)
//   btn         : raw asynchronous button levels, active high
//   evt         : event handshake (evt_valid / evt_id / evt_ready), master side
//   pending     : per-channel pending event flags
//   overrun     : sticky flag, an event was dropped on an already pending channel
//   clr_overrun : clears overrun on the next edge (a simultaneous set wins)
// -----------------------------------------------------------------------------
module button_event_arbiter #(
    parameter int NUM_BTN   = 4,
    parameter int ID_W      = 2,
    parameter int DB_CYCLES = 10000,
    parameter int CNT_W     = 16
) (
    input  logic                  MHz10,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [NUM_BTN-1:0]    btn,
    button_event_arbiter_if.master evt,
    output logic [NUM_BTN-1:0]    pending,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Per-channel debounced 0->1 edge, and "this channel is being accepted now"
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] accept_hit;

    logic               accept;

    state_t             state_reg, state_next;
    logic               evt_valid_reg, evt_valid_next;
    logic [ID_W-1:0]    evt_id_reg, evt_id_next;
    logic [ID_W-1:0]    last_grant_reg, last_grant_next;
    logic [NUM_BTN-1:0] pending_reg, pending_next;
    logic               overrun_reg, overrun_next;
    logic               overrun_set;

    logic               sel_found;
    logic [ID_W-1:0]    sel_idx;
    logic [ID_W-1:0]    cand_id;

    assign accept = (state_reg == OFFER) && evt.evt_ready;

    // -------------------------------------------------------------------------
    // Per-channel synchronizer and debouncer
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : gen_ch
            logic             s1_reg;
            logic             s2_reg;
            logic             db_reg;
            logic [CNT_W-1:0] cnt_reg;

            // The synchronizer keeps running while en is low so that a level
            // seen after re-enable is already metastability-safe.
            always_ff @(posedge MHz10) begin
                if (!nrst) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= btn[gi];
                    s2_reg <= s1_reg;
                end
            end

            // db changes only after DB_CYCLES consecutive mismatching samples;
            // any matching sample restarts the count.
            always_ff @(posedge MHz10) begin
                if (!nrst) begin
                    db_reg  <= 1'b0;
                    cnt_reg <= '0;
                end else if (en) begin
                    if (s2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        db_reg  <= s2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            // Only a 0->1 acceptance creates an event
            assign rise[gi] = en && s2_reg && !db_reg && (cnt_reg == CNT_LAST);

            assign accept_hit[gi] = accept && (evt_id_reg == ID_W'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Pending flags and overrun
    // -------------------------------------------------------------------------
    // A new rise on the very edge its channel is accepted re-arms the flag
    // instead of counting as a loss.
    assign pending_next = (pending_reg & ~accept_hit) | rise;
    assign overrun_set  = |(rise & pending_reg & ~accept_hit);
    assign overrun_next = overrun_set | (overrun_reg & ~clr_overrun);

    // -------------------------------------------------------------------------
    // Round-robin search: first pending bit above last_grant, wrapping around.
    // last_grant itself is visited last so a lone requester is still served.
    // -------------------------------------------------------------------------
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_id   = '0;
        for (int off = 1; off <= NUM_BTN; off++) begin
            cand_id = ID_W'((int'(last_grant_reg) + off) % NUM_BTN);
            if (!sel_found && pending_reg[cand_id]) begin
                sel_found = 1'b1;
                sel_idx   = cand_id;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Offer FSM: next-state and registered outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        evt_valid_next  = evt_valid_reg;
        evt_id_next     = evt_id_reg;
        last_grant_next = last_grant_reg;

        case (state_reg)
            IDLE: begin
                // evt_ready is deliberately ignored here
                evt_valid_next = 1'b0;
                if (sel_found) begin
                    evt_id_next    = sel_idx;
                    evt_valid_next = 1'b1;
                    state_next     = OFFER;
                end
            end
            OFFER: begin
                // An offer in progress is held regardless of en
                evt_valid_next = 1'b1;
                if (evt.evt_ready) begin
                    last_grant_next = evt_id_reg;
                    evt_valid_next  = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: begin
                evt_valid_next = 1'b0;
                state_next     = IDLE;
            end
        endcase
    end

    always_ff @(posedge MHz10) begin
        if (!nrst) begin
            state_reg      <= IDLE;
            evt_valid_reg  <= 1'b0;
            evt_id_reg     <= '0;
            // Start the rotation so that channel 0 wins the first arbitration
            last_grant_reg <= ID_W'(NUM_BTN - 1);
            pending_reg    <= '0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            evt_valid_reg  <= evt_valid_next;
            evt_id_reg     <= evt_id_next;
            last_grant_reg <= last_grant_next;
            pending_reg    <= pending_next;
            overrun_reg    <= overrun_next;
        end
    end

    assign evt.evt_valid = evt_valid_reg;
    assign evt.evt_id    = evt_id_reg;
    assign pending       = pending_reg;
    assign overrun       = overrun_reg;

endmodule
